// File: rtl/axel_stream_pe.sv
// Streaming processing element: ch0 adds consecutive word pairs lane-wise, ch1 emits a lane-wise prefix sum.
// Optional AXEL_PE_TRACE_EN adds a simulation-only print of every output word; logic is otherwise identical.

module axel_stream_pe_chan #(
    parameter int DATA_WIDTH  = 128,
    parameter int LANE_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter bit PREFIX_MODE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  rd,
    input  logic                  vld,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  wr,
    input  logic                  full,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int LANES = DATA_WIDTH / LANE_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int SW    = CW + 1;

    function automatic logic [DATA_WIDTH-1:0] lane_add(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] s;
        s = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            s[k*LANE_W +: LANE_W] = a[k*LANE_W +: LANE_W] + b[k*LANE_W +: LANE_W];
        end
        return s;
    endfunction

    logic                  rd_r;
    logic                  phase_r;
    logic [CW-1:0]         outst_r;
    logic [CW-1:0]         cnt_r;
    logic [AW-1:0]         wptr_r;
    logic [AW-1:0]         rptr_r;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

    logic                  not_empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  rd_nxt_s;
    logic                  phase_nxt_s;
    logic [DATA_WIDTH-1:0] push_data_s;
    logic [DATA_WIDTH-1:0] hold_nxt_s;
    logic [CW-1:0]         outst_nxt_s;
    logic [CW-1:0]         cnt_nxt_s;
    logic [SW-1:0]         commit_s;

    assign not_empty_s = (cnt_r != {CW{1'b0}});
    assign pop_s       = not_empty_s & ~full;
    assign wr          = pop_s;
    assign rd          = rd_r;
    assign data_out    = not_empty_s ? mem_r[rptr_r] : {DATA_WIDTH{1'b0}};

    // Datapath: hold_r is the pending A word (pair mode) or the accumulator (prefix mode)
    always_comb begin
        push_data_s = lane_add(hold_r, data_in);
        push_s      = 1'b0;
        hold_nxt_s  = hold_r;
        phase_nxt_s = phase_r;
        if (PREFIX_MODE) begin
            if (vld) begin
                push_s     = 1'b1;
                hold_nxt_s = push_data_s;
            end else begin
                push_s = 1'b0;
            end
        end else begin
            if (vld) begin
                if (phase_r) begin
                    push_s      = 1'b1;
                    phase_nxt_s = 1'b0;
                end else begin
                    hold_nxt_s  = data_in;
                    phase_nxt_s = 1'b1;
                end
            end else begin
                push_s = 1'b0;
            end
        end
    end

    // Credit: words queued plus reads in flight (including this cycle's) must leave a free slot
    always_comb begin
        commit_s = SW'(cnt_r) + SW'(outst_r) + SW'(rd_r);
        rd_nxt_s = (commit_s < SW'(FIFO_DEPTH));
        case ({rd_r, vld})
            2'b10:   outst_nxt_s = outst_r + CW'(1);
            2'b01:   outst_nxt_s = (outst_r == {CW{1'b0}}) ? {CW{1'b0}} : outst_r - CW'(1);
            default: outst_nxt_s = outst_r;
        endcase
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CW'(1);
            2'b01:   cnt_nxt_s = cnt_r - CW'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // State registers and FIFO storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_r    <= 1'b0;
            phase_r <= 1'b0;
            outst_r <= {CW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            hold_r  <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            rd_r    <= rd_nxt_s;
            phase_r <= phase_nxt_s;
            outst_r <= outst_nxt_s;
            cnt_r   <= cnt_nxt_s;
            hold_r  <= hold_nxt_s;
            if (push_s) begin
                mem_r[wptr_r] <= push_data_s;
                wptr_r        <= wptr_r + AW'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end else begin
                rptr_r <= rptr_r;
            end
        end
    end

endmodule

module axel_stream_pe #(
    parameter int DATA_WIDTH = 128,
    parameter int LANE_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  rd0,
    input  logic                  vld0,
    input  logic [DATA_WIDTH-1:0] data_in0,
    output logic                  wr0,
    input  logic                  full0,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic                  rd1,
    input  logic                  vld1,
    input  logic [DATA_WIDTH-1:0] data_in1,
    output logic                  wr1,
    input  logic                  full1,
    output logic [DATA_WIDTH-1:0] data_out1
);

    axel_stream_pe_chan #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_W     (LANE_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PREFIX_MODE(1'b0)
    ) u_ch0 (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd0),
        .vld     (vld0),
        .data_in (data_in0),
        .wr      (wr0),
        .full    (full0),
        .data_out(data_out0)
    );

    axel_stream_pe_chan #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_W     (LANE_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PREFIX_MODE(1'b1)
    ) u_ch1 (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd1),
        .vld     (vld1),
        .data_in (data_in1),
        .wr      (wr1),
        .full    (full1),
        .data_out(data_out1)
    );

`ifdef AXEL_PE_TRACE_EN
    // Simulation trace of every word written back to either adapter
    always @(posedge clk) begin
        if (wr0) begin
            $display("PE ch0 out: %h", data_out0);
        end
        if (wr1) begin
            $display("PE ch1 out: %h", data_out1);
        end
    end
`else
`endif

endmodule

// File: tb/tb_axel_stream_pe.sv
// Directed, table-driven bench for axel_stream_pe with a bench-side sma responder per channel.

module tb_axel_stream_pe;

    logic         clk;
    logic         reset;
    logic         rd0, vld0, wr0, full0;
    logic         rd1, vld1, wr1, full1;
    logic [127:0] data_in0, data_out0, data_in1, data_out1;

    axel_stream_pe dut (
        .clk(clk), .reset(reset),
        .rd0(rd0), .vld0(vld0), .data_in0(data_in0), .wr0(wr0), .full0(full0), .data_out0(data_out0),
        .rd1(rd1), .vld1(vld1), .data_in1(data_in1), .wr1(wr1), .full1(full1), .data_out1(data_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [127:0] a; logic [127:0] b; logic [127:0] y; } vec0_t;
    typedef struct { logic [127:0] din; logic [127:0] y; } vec1_t;

    int tests = 0;
    int fails = 0;
    int pend0 = 0, pend1 = 0, ndel0 = 0, ndel1 = 0;
    logic [127:0] src0[$], src1[$], cap0[$], cap1[$];

    function automatic logic [127:0] mk(input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [127:0] qget(input logic [127:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return {128{1'bx}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: responder drives vld/data for earlier reads, then records rd and outputs
    task automatic tick();
        if (!reset && pend0 > 0 && src0.size() > 0) begin
            vld0 = 1'b1; data_in0 = src0.pop_front(); pend0--; ndel0++;
        end else begin
            vld0 = 1'b0; data_in0 = 128'd0;
        end
        if (!reset && pend1 > 0 && src1.size() > 0) begin
            vld1 = 1'b1; data_in1 = src1.pop_front(); pend1--; ndel1++;
        end else begin
            vld1 = 1'b0; data_in1 = 128'd0;
        end
        #1;
        if (reset) begin
            pend0 = 0; pend1 = 0;
        end else begin
            if (rd0) pend0++;
            if (rd1) pend1++;
            if (wr0) cap0.push_back(data_out0);
            if (wr1) cap1.push_back(data_out1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        src0.delete(); src1.delete(); cap0.delete(); cap1.delete();
        ndel0 = 0; ndel1 = 0;
    endtask

    vec0_t t0[4];
    vec1_t t1[4];

    initial begin
        t0[0] = '{mk(32'h1, 32'h2, 32'h3, 32'h4), mk(32'h0A, 32'h14, 32'h1E, 32'h28), mk(32'h0B, 32'h16, 32'h21, 32'h2C)};
        t0[1] = '{mk(32'hFFFFFFFF, 32'h0, 32'h0, 32'h1), mk(32'h1, 32'h0, 32'h0, 32'h1), mk(32'h0, 32'h0, 32'h0, 32'h2)};
        t0[2] = '{mk(32'h80000000, 32'h7, 32'h0, 32'hFFFFFFFF), mk(32'h80000000, 32'h8, 32'h5, 32'hFFFFFFFF),
                  mk(32'h0, 32'hF, 32'h5, 32'hFFFFFFFE)};
        t0[3] = '{mk(32'h100, 32'h200, 32'h300, 32'h400), mk(32'h1, 32'h2, 32'h3, 32'h4), mk(32'h101, 32'h202, 32'h303, 32'h404)};
        t1[0] = '{mk(32'h1, 32'h1, 32'h1, 32'h1), mk(32'h1, 32'h1, 32'h1, 32'h1)};
        t1[1] = '{mk(32'h1, 32'h1, 32'h1, 32'h1), mk(32'h2, 32'h2, 32'h2, 32'h2)};
        t1[2] = '{mk(32'h1, 32'h1, 32'h1, 32'h1), mk(32'h3, 32'h3, 32'h3, 32'h3)};
        t1[3] = '{mk(32'hFFFFFFFF, 32'h1, 32'h0, 32'h10), mk(32'h2, 32'h4, 32'h3, 32'h13)};

        reset = 1'b1; full0 = 1'b0; full1 = 1'b0;
        vld0 = 1'b0; vld1 = 1'b0; data_in0 = 128'd0; data_in1 = 128'd0;
        @(posedge clk); #1;
        tick(); tick();

        // Reset state
        check("reset_rd0", {127'd0, rd0}, 128'd0);
        check("reset_rd1", {127'd0, rd1}, 128'd0);
        check("reset_wr0", {127'd0, wr0}, 128'd0);
        check("reset_wr1", {127'd0, wr1}, 128'd0);
        check("reset_dout0", data_out0, 128'd0);
        check("reset_dout1", data_out1, 128'd0);
        reset = 1'b0;
        tick();
        check("release_rd0", {127'd0, rd0}, 128'd1);
        check("release_rd1", {127'd0, rd1}, 128'd1);

        // Table vectors: ch0 pairs and ch1 prefix sums run concurrently
        for (int i = 0; i < 4; i++) begin
            src0.push_back(t0[i].a);
            src0.push_back(t0[i].b);
            src1.push_back(t1[i].din);
        end
        for (int n = 0; n < 300 && (cap0.size() < 4 || cap1.size() < 4); n++) tick();
        repeat (10) tick();
        check("tab_ch0_count", 128'(cap0.size()), 128'd4);
        check("tab_ch1_count", 128'(cap1.size()), 128'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tab_ch0_out%0d", i), qget(cap0, i), t0[i].y);
            check($sformatf("tab_ch1_out%0d", i), qget(cap1, i), t1[i].y);
        end

        // Back-pressure on ch1: only FIFO_DEPTH words may be accepted while full1 is held
        pulse_reset();
        full1 = 1'b1;
        for (int k = 1; k <= 6; k++) src1.push_back(mk(k, k, k, k));
        repeat (20) tick();
        check("stall_accepted", 128'(ndel1), 128'd4);
        check("stall_no_wr", 128'(cap1.size()), 128'd0);
        check("stall_rd1_low", {127'd0, rd1}, 128'd0);
        check("stall_wr1_low", {127'd0, wr1}, 128'd0);
        full1 = 1'b0;
        for (int n = 0; n < 200 && cap1.size() < 6; n++) tick();
        repeat (10) tick();
        check("stall_total", 128'(cap1.size()), 128'd6);
        for (int k = 1; k <= 6; k++) begin
            logic [31:0] ps;
            ps = 32'(k * (k + 1) / 2);
            check($sformatf("stall_out%0d", k), qget(cap1, k - 1), mk(ps, ps, ps, ps));
        end

        // Reset mid-stream: pending A on ch0 and acc on ch1 are discarded
        pulse_reset();
        src0.push_back(mk(32'h5, 32'h5, 32'h5, 32'h5));
        src1.push_back(mk(32'h7, 32'h7, 32'h7, 32'h7));
        for (int n = 0; n < 50 && (ndel0 < 1 || cap1.size() < 1); n++) tick();
        repeat (3) tick();
        check("mid_a_no_out", 128'(cap0.size()), 128'd0);
        check("mid_acc_pre", qget(cap1, 0), mk(32'h7, 32'h7, 32'h7, 32'h7));
        pulse_reset();
        src0.push_back(mk(32'h1, 32'h2, 32'h3, 32'h4));
        src0.push_back(mk(32'h0A, 32'h14, 32'h1E, 32'h28));
        src1.push_back(mk(32'h2, 32'h2, 32'h2, 32'h2));
        for (int n = 0; n < 50 && (cap0.size() < 1 || cap1.size() < 1); n++) tick();
        repeat (10) tick();
        check("mid_ch0_count", 128'(cap0.size()), 128'd1);
        check("mid_ch0_pair", qget(cap0, 0), mk(32'h0B, 32'h16, 32'h21, 32'h2C));
        check("mid_ch1_restart", qget(cap1, 0), mk(32'h2, 32'h2, 32'h2, 32'h2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
